// File: rtl/imm_gen_skid_if.sv
// Valid/ready bundle for the immediate generator.
// The master side drives the word and consumes the result.
interface imm_gen_skid_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_err;

    modport master (
        output in_valid, instr, imm_sel, out_ready,
        input  in_ready, out_valid, out_imm, out_err
    );

    modport slave (
        input  in_valid, instr, imm_sel, out_ready,
        output in_ready, out_valid, out_imm, out_err
    );
endinterface

// File: rtl/imm_gen_skid.sv
// RV immediate generator with a 2-entry skid buffer.
// in_ready comes straight from a flop; main register M drives the outputs.
module imm_gen_skid #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_skid_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rdy;
    logic [XLEN-1:0] m_imm;
    logic            m_err;
    logic [XLEN-1:0] k_imm;
    logic            k_err;

    logic [31:0]     raw;
    logic            sext;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    logic            push;
    logic            pop;
    logic            load_m;
    logic            load_k;
    logic            m_from_k;

    // Every format is assembled as a 32-bit pattern, then widened.
    always_comb begin
        raw     = '0;
        sext    = 1'b1;
        dec_err = 1'b0;
        case (bus.imm_sel)
            3'd0: raw = {{20{bus.instr[31]}}, bus.instr[31:20]};
            3'd1: raw = {{20{bus.instr[31]}}, bus.instr[31:25],
                         bus.instr[11:7]};
            3'd2: raw = {{20{bus.instr[31]}}, bus.instr[7],
                         bus.instr[30:25], bus.instr[11:8], 1'b0};
            3'd3: raw = {bus.instr[31:12], 12'b0};
            3'd4: raw = {{12{bus.instr[31]}}, bus.instr[19:12],
                         bus.instr[20], bus.instr[30:21], 1'b0};
            3'd5: begin
                raw  = {27'b0, bus.instr[19:15]};
                sext = 1'b0;
            end
            3'd6: begin
                raw  = 32'(bus.instr[20 +: SHAMT_W]);
                sext = 1'b0;
            end
            default: begin
                sext    = 1'b0;
                dec_err = 1'b1;
            end
        endcase
        dec_imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);
    end

    assign push = bus.in_valid & rdy;
    assign pop  = (state != EMPTY) & bus.out_ready;

    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_k    = 1'b0;
        m_from_k  = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_m    = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = TWO;
                    load_k    = 1'b1;
                end else if (push && pop) begin
                    load_m    = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt = ONE;
                    m_from_k  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            rdy   <= 1'b1;
        end else begin
            state <= state_nxt;
            rdy   <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_imm <= '0;
            m_err <= 1'b0;
            k_imm <= '0;
            k_err <= 1'b0;
        end else begin
            if (load_m) begin
                m_imm <= dec_imm;
                m_err <= dec_err;
            end else if (m_from_k) begin
                m_imm <= k_imm;
                m_err <= k_err;
            end
            if (load_k) begin
                k_imm <= dec_imm;
                k_err <= dec_err;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_imm   = m_imm;
    assign bus.out_err   = m_err;
endmodule

// File: doc/imm_gen_skid.md
Name: imm_gen_skid

Overview:
- Parametrised RV immediate generator for the decode stage; successor of the single-format 12-bit sign extender.
- Decodes all base immediate formats (I, S, B, U, J, CSR zimm, shamt) from a full 32-bit instruction word and extends the result to XLEN.
- Valid/ready interface on both sides, with a 2-entry skid buffer so that in_ready is driven directly from a flop.
- Sits between the fetch/decode register and the execute operand mux.

Parameters:
- XLEN, 32, output width; legal values are 32 and 64. Sign extension replicates instr[31] up to XLEN-1.
- SHAMT_W, 5, shamt field width; use 5 for RV32 and 6 for RV64 (instr[25:20]).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  buffer can accept a word; registered
- instr  in  32  instruction word
- imm_sel  in  3  format select: 0=I 1=S 2=B 3=U 4=J 5=ZIMM 6=SHAMT 7=reserved
- out_valid  out  1  out_imm valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_err  out  1  entry was decoded with imm_sel=7

Behaviour:
- Decode is combinational on the input side; the result is stored as {imm, err}. Raw instr is not stored.
- Formats, with s = instr[31] replicated to XLEN:
  - I: s, instr[31:20]
  - S: s, instr[31:25], instr[11:7]
  - B: s, instr[7], instr[30:25], instr[11:8], 0
  - U: s above bit 31, instr[31:12], 12'b0
  - J: s, instr[19:12], instr[20], instr[30:21], 0
  - ZIMM: zero-extended instr[19:15]
  - SHAMT: zero-extended instr[20+SHAMT_W-1:20]
  - sel 7: imm=0, err=1. All other selects give err=0.
- Storage: main register M, which drives the outputs, and skid register K.
- States:
  - EMPTY: M and K invalid.
  - ONE: M valid.
  - TWO: M and K valid.
- Handshake signals:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- Transitions:
  - EMPTY, push -> ONE; M <= decoded input.
  - ONE, push & !pop -> TWO; K <= input.
  - ONE, push & pop -> ONE; M <= input.
  - ONE, !push & pop -> EMPTY.
  - TWO, pop -> ONE; M <= K. No push is possible in TWO because in_ready=0.
  - All other cases hold state.
- Outputs:
  - out_valid = 1 in ONE or TWO.
  - in_ready flop = 1 in EMPTY and ONE, 0 in TWO; it updates on the same edge as the state.
- Latency: 1 cycle from push to out_valid when the block is EMPTY. Throughput is 1 word/cycle when out_ready=1.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- out_imm and out_err hold stable while out_valid=1 and out_ready=0.
- in_valid while in_ready=0 is ignored; the upstream stage holds its word.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - state=EMPTY, out_valid=0, in_ready=1, out_imm=0, out_err=0, K contents=0.
  - Reset mid-operation discards all buffered words. The first push after release behaves as from EMPTY.
- Unknown or X imm_sel while in_valid=0 must not affect state.

Test Plan:
- XLEN=32, out_ready=1:
  - I 0xFFF00093 -> 0xFFFFFFFF
  - S 0xFE112E23 -> 0xFFFFFFFC
  - U 0x123450B7 -> 0x12345000
  - Each appears 1 cycle after its push; out_err=0.
- B 0x80000063 -> 0xFFFFF000; J 0x8000006F -> 0xFFF00000; ZIMM 0x000F8073 -> 0x0000001F; SHAMT(5) 0x01F0D093 -> 0x0000001F.
- sel=7 with any instr -> out_imm=0 and out_err=1. A following I word -> out_err=0.
- Backpressure:
  - Hold out_ready=0 and push A, B, C back-to-back.
  - in_ready falls after B is accepted; C is held upstream.
  - out_imm stays at A.
  - Raise out_ready -> outputs A, B, C on consecutive cycles, in order.
- XLEN=64 with I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. U 0x800000B7 -> 0xFFFFFFFF80000000.
- Reset mid-operation:
  - Enter TWO, then pulse rst_n low mid-cycle.
  - Immediately: out_valid=0, in_ready=1, out_imm=0.
  - After release, the next push appears with 1-cycle latency; the old words never appear.
